rom_dl_router: RTL and testbench
================================

# rom_dl_router

Download front end that sits directly upstream of the Crazy Kong core's `dn_addr`/`dn_data`/`dn_wr` port. It registers the HPS ioctl byte stream, decodes each byte address into a one-hot ROM-region select, and suppresses writes outside the loaded image. It also owns the core's reset during and after a download, releasing the core only after a fixed drain interval. The download is valid only if the image length matches exactly; that result is reported as a status flag.

## Interface
Parameters
- `ADDR_W`, default 17: width of the core download address.
- `PRG_END`, default 17'h06000: first address past the CPU program ROM.
- `GFX_END`, default 17'h0A000: first address past the tile/sprite ROMs.
- `SND_END`, default 17'h0C000: first address past the sound/colour ROMs. This is also the required image length.
- `HOLD_CYC`, default 16: number of `clk_sys` cycles the core stays in reset after the download ends.

Ports
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `ioctl_download` in 1: a download is in progress.
- `ioctl_wr` in 1: byte strobe, one cycle wide.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `dn_addr` out ADDR_W: registered address to the core.
- `dn_data` out 8: registered data to the core.
- `dn_wr` out 1: registered write strobe to the core.
- `rom_sel` out 3: one-hot region select, bit0 = program, bit1 = graphics, bit2 = sound. Valid while `dn_wr` is high.
- `core_reset` out 1: reset for the core.
- `dl_ok` out 1: the last download completed with exactly SND_END bytes.
- `dl_err` out 1: the last download contained an out-of-range address or had a wrong length.

## Operation
- States:
  - IDLE: reset state. Entered on reset only.
  - LOAD
  - HOLD
  - RUN
- Transitions:
  - IDLE→LOAD when `ioctl_download` is 1. IDLE→RUN is not used; the core stays in reset until a first download completes.
  - RUN→LOAD when `ioctl_download` rises.
  - LOAD→HOLD when `ioctl_download` falls. The hold counter is loaded with HOLD_CYC-1.
  - HOLD→RUN when the counter reaches 0.
  - HOLD→LOAD if `ioctl_download` rises during the hold interval. The counter is abandoned.
- `core_reset` is 1 in IDLE, LOAD and HOLD, and 0 only in RUN.
- Entering LOAD clears the byte counter, `dl_ok` and `dl_err`.
- Per strobe in LOAD:
  - If `ioctl_addr < SND_END`: forward the byte (`dn_wr` = 1 the next cycle), set `rom_sel` by comparing against PRG_END and GFX_END, and increment the byte counter.
  - If `ioctl_addr ≥ SND_END` (all 25 bits are compared): set `dl_err`, hold `dn_wr` at 0, and do not increment the counter.
- Strobes outside LOAD are ignored; no `dn_wr` is issued.
- On LOAD→HOLD:
  - `dl_ok` = (count == SND_END) && !`dl_err`.
  - If count ≠ SND_END, `dl_err` is set.
- Byte counter: ADDR_W+1 bits, saturating at all-ones. Duplicate addresses each count, so a repeated byte produces a length error.
- `dn_addr` = `ioctl_addr[ADDR_W-1:0]`, registered.

## Timing
- Latency: `dn_*` and `rom_sel` follow `ioctl_*` by exactly 1 cycle. `dn_wr` is 1 cycle wide.
- `dn_addr` and `dn_data` hold their last value between strobes.
- `core_reset`:
  - Rises the cycle after `ioctl_download` rises.
  - Falls exactly HOLD_CYC+1 cycles after `ioctl_download` falls.
- The final strobe may coincide with the falling edge of `ioctl_download`. That byte is still forwarded and counted before `dl_ok` is evaluated; evaluation uses the next-count value.
- Reset values, asserted asynchronously and held while `reset` = 1:
  - state = IDLE
  - `core_reset` = 1
  - `dn_wr` = 0
  - `dn_addr` = 0
  - `dn_data` = 0
  - `rom_sel` = 0
  - `dl_ok` = 0
  - `dl_err` = 0
  - counters = 0
- A reset during LOAD discards progress. A subsequent download starts clean.

## Structure
- Shared package `ckong_pkg`:
  - state enum `dl_state_t`
  - region index constants `RGN_PRG`, `RGN_GFX`, `RGN_SND`
  - default region bounds
- Sub-module `rom_region_dec` (combinational): address in, one-hot `rom_sel` and `in_range` out. It is reused by the verification scoreboard.
- The FSM, counters and output registers live in `rom_dl_router`.

## Test plan
- Full image: stream 0x0000–0xBFFF, then drop `ioctl_download`.
  - `dn_wr` count = 49152.
  - `rom_sel` = 001 at 0x5FFF, 010 at 0x6000, 100 at 0xA000.
  - `dl_ok` = 1, `dl_err` = 0.
  - `core_reset` falls 17 cycles after the download drops.
- Short image: stream 0x0000–0x0FFF only → `dl_ok` = 0, `dl_err` = 1. The core is still released after HOLD.
- Overrun: one strobe at 0x0C000 inside a full image → no `dn_wr` for that strobe, `dl_err` = 1, `dl_ok` = 0.
- Re-download: raise `ioctl_download` 5 cycles into HOLD → `core_reset` stays 1 and `dl_ok` clears. The second full image ends with `dl_ok` = 1.
- Async reset mid-LOAD at byte 0x1234:
  - All outputs take reset values immediately, with `core_reset` = 1.
  - A following full image gives `dl_ok` = 1.
- Edge strobe: last strobe (0xBFFF) in the same cycle `ioctl_download` falls → `dn_wr` is issued and `dl_ok` = 1.

Source files
------------

// File: rtl/ckong_pkg.sv
// ----------------------------------------------------------------------------
// ckong_pkg: shared types and default ROM map for the Crazy Kong download path
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ckong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } dl_state_t;

  localparam int RGN_PRG = 0;
  localparam int RGN_GFX = 1;
  localparam int RGN_SND = 2;

  localparam int          DEF_ADDR_W   = 17;
  localparam logic [16:0] DEF_PRG_END  = 17'h06000;
  localparam logic [16:0] DEF_GFX_END  = 17'h0A000;
  localparam logic [16:0] DEF_SND_END  = 17'h0C000;
  localparam int          DEF_HOLD_CYC = 16;

endpackage

`default_nettype wire

// File: rtl/rom_dl_router_if.sv
// ----------------------------------------------------------------------------
// rom_dl_router_if: HPS ioctl stream in, core download port and status out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface rom_dl_router_if #(
  parameter int ADDR_W = 17
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic [2:0]        rom_sel;
  logic              core_reset;
  logic              dl_ok;
  logic              dl_err;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr, rom_sel, core_reset, dl_ok, dl_err
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr, rom_sel, core_reset, dl_ok, dl_err
  );
endinterface

`default_nettype wire

// File: rtl/rom_region_dec.sv
// ----------------------------------------------------------------------------
// rom_region_dec: byte address to one-hot ROM region select plus range flag
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rom_region_dec
  import ckong_pkg::*;
#(
  parameter int                ADDR_W  = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] PRG_END = ADDR_W'(DEF_PRG_END),
  parameter logic [ADDR_W-1:0] GFX_END = ADDR_W'(DEF_GFX_END),
  parameter logic [ADDR_W-1:0] SND_END = ADDR_W'(DEF_SND_END)
) (
  input  logic [24:0] i_addr,
  output logic [2:0]  rom_sel,
  output logic        in_range
);

  // Full 25-bit compare so stray high address bits can never alias into the image
  localparam logic [24:0] c_PRG_END = 25'(PRG_END);
  localparam logic [24:0] c_GFX_END = 25'(GFX_END);
  localparam logic [24:0] c_SND_END = 25'(SND_END);

  always_comb begin
    rom_sel  = '0;
    in_range = (i_addr < c_SND_END);
    if (i_addr < c_PRG_END) begin
      rom_sel[RGN_PRG] = 1'b1;
    end else if (i_addr < c_GFX_END) begin
      rom_sel[RGN_GFX] = 1'b1;
    end else if (i_addr < c_SND_END) begin
      rom_sel[RGN_SND] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rom_dl_router.sv
// ----------------------------------------------------------------------------
// rom_dl_router: registers the ioctl stream, gates writes to the image, owns core reset
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rom_dl_router
  import ckong_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] PRG_END  = ADDR_W'(DEF_PRG_END),
  parameter logic [ADDR_W-1:0] GFX_END  = ADDR_W'(DEF_GFX_END),
  parameter logic [ADDR_W-1:0] SND_END  = ADDR_W'(DEF_SND_END),
  parameter int                HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic         clk_sys,
  input  logic         reset,
  rom_dl_router_if.slave bus
);

  localparam int                 c_CNT_W     = ADDR_W + 1;
  localparam int                 c_HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_IMG_LEN   = c_CNT_W'(SND_END);
  localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(HOLD_CYC - 1);

  dl_state_t           r_state;
  dl_state_t           w_state_nxt;
  logic                r_dl_q;
  logic [c_CNT_W-1:0]  r_byte_cnt;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [ADDR_W-1:0]   r_dn_addr;
  logic [7:0]          r_dn_data;
  logic                r_dn_wr;
  logic [2:0]          r_rom_sel;
  logic                r_dl_ok;
  logic                r_dl_err;

  logic [2:0]          w_sel;
  logic                w_in_range;
  logic                w_dl_rise;
  logic                w_strobe;
  logic                w_fwd;
  logic                w_load_enter;
  logic                w_load_exit;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic                w_err_nxt;
  logic                w_core_reset;

  rom_region_dec #(
    .ADDR_W  (ADDR_W),
    .PRG_END (PRG_END),
    .GFX_END (GFX_END),
    .SND_END (SND_END)
  ) u_dec (
    .i_addr   (bus.ioctl_addr),
    .rom_sel  (w_sel),
    .in_range (w_in_range)
  );

  assign w_dl_rise    = bus.ioctl_download & ~r_dl_q;
  assign w_strobe     = bus.ioctl_wr & (r_state == ST_LOAD);
  assign w_fwd        = w_strobe & w_in_range;
  assign w_load_enter = (r_state != ST_LOAD) && (w_state_nxt == ST_LOAD);
  assign w_load_exit  = (r_state == ST_LOAD) && (w_state_nxt == ST_HOLD);
  // A strobe coinciding with the download drop must be counted before the length check
  assign w_cnt_nxt    = (w_fwd && (r_byte_cnt != '1)) ? r_byte_cnt + c_CNT_W'(1) : r_byte_cnt;
  assign w_err_nxt    = r_dl_err | (w_strobe & ~w_in_range);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.ioctl_download) w_state_nxt = ST_LOAD;
      ST_LOAD: if (!bus.ioctl_download) w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (w_dl_rise) begin
          w_state_nxt = ST_LOAD;
        end else if (r_hold_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN:  if (w_dl_rise) w_state_nxt = ST_LOAD;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_core_reset = (r_state != ST_RUN);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dl_q     <= 1'b0;
      r_byte_cnt <= '0;
      r_hold_cnt <= '0;
      r_dn_addr  <= '0;
      r_dn_data  <= '0;
      r_dn_wr    <= 1'b0;
      r_rom_sel  <= '0;
      r_dl_ok    <= 1'b0;
      r_dl_err   <= 1'b0;
    end else begin
      r_dl_q  <= bus.ioctl_download;
      r_dn_wr <= w_fwd;
      if (w_fwd) begin
        r_dn_addr <= bus.ioctl_addr[ADDR_W-1:0];
        r_dn_data <= bus.ioctl_dout;
        r_rom_sel <= w_sel;
      end
      if (w_load_enter) begin
        r_byte_cnt <= '0;
        r_dl_ok    <= 1'b0;
        r_dl_err   <= 1'b0;
      end else if (r_state == ST_LOAD) begin
        r_byte_cnt <= w_cnt_nxt;
        r_dl_err   <= w_err_nxt;
        if (w_load_exit) begin
          r_dl_ok    <= (w_cnt_nxt == c_IMG_LEN) && !w_err_nxt;
          r_dl_err   <= w_err_nxt | (w_cnt_nxt != c_IMG_LEN);
          r_hold_cnt <= c_HOLD_INIT;
        end
      end else if ((r_state == ST_HOLD) && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - c_HOLD_W'(1);
      end
    end
  end

  assign bus.dn_addr    = r_dn_addr;
  assign bus.dn_data    = r_dn_data;
  assign bus.dn_wr      = r_dn_wr;
  assign bus.rom_sel    = r_rom_sel;
  assign bus.core_reset = w_core_reset;
  assign bus.dl_ok      = r_dl_ok;
  assign bus.dl_err     = r_dl_err;

endmodule

`default_nettype wire

// File: tb/tb_rom_dl_router.sv
// ----------------------------------------------------------------------------
// tb_rom_dl_router: directed bench for the download router on a scaled ROM map
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rom_dl_router;

  localparam int          ADDR_W = 17;
  localparam logic [24:0] P_END  = 25'h00C00;
  localparam logic [24:0] G_END  = 25'h01400;
  localparam logic [24:0] S_END  = 25'h01800;
  localparam int          HOLD   = 16;

  typedef struct {
    logic [24:0] addr;
    logic        wr;
    logic [2:0]  sel;
    logic        err;
  } vec_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   wr_seen  = 0;

  rom_dl_router_if #(.ADDR_W(ADDR_W)) bus ();

  rom_dl_router #(
    .ADDR_W   (ADDR_W),
    .PRG_END  (17'(P_END)),
    .GFX_END  (17'(G_END)),
    .SND_END  (17'(S_END)),
    .HOLD_CYC (HOLD)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) if (bus.dn_wr === 1'b1) wr_seen++;

  function automatic logic [7:0] dat(input logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [2:0] exp_sel(input logic [24:0] a);
    if (a < P_END) return 3'b001;
    if (a < G_END) return 3'b010;
    if (a < S_END) return 3'b100;
    return 3'b000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_dl();
    @(posedge clk_sys); #1 bus.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  // Compare the registered outputs against the byte sampled one edge earlier
  task automatic chk_byte(input logic [24:0] a, inout int mism);
    logic exp_wr;
    exp_wr = (a < S_END);
    if (bus.dn_wr !== exp_wr) mism++;
    if (exp_wr) begin
      if (bus.dn_addr !== a[16:0]) mism++;
      if (bus.dn_data !== dat(a)) mism++;
      if (bus.rom_sel !== exp_sel(a)) mism++;
    end
    if (a == P_END - 1) chk("sel_prg_last", {29'd0, bus.rom_sel}, 32'b001);
    if (a == P_END)     chk("sel_gfx_first", {29'd0, bus.rom_sel}, 32'b010);
    if (a == G_END)     chk("sel_snd_first", {29'd0, bus.rom_sel}, 32'b100);
  endtask

  task automatic stream(input string tag, input int hi, input bit edge_drop, input int bad_at);
    logic [24:0] q[$];
    int mism;
    mism = 0;
    for (int a = 0; a < hi; a++) begin
      if (a == bad_at) q.push_back(S_END);
      q.push_back(25'(a));
    end
    for (int k = 0; k < q.size(); k++) begin
      @(posedge clk_sys); #1;
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = q[k];
      bus.ioctl_dout = dat(q[k]);
      if (edge_drop && (k == q.size() - 1)) bus.ioctl_download = 1'b0;
      @(negedge clk_sys);
      if (k > 0) chk_byte(q[k-1], mism);
    end
    @(posedge clk_sys); #1;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    chk_byte(q[q.size()-1], mism);
    chk({"stream_", tag}, mism, 0);
  endtask

  // start = clock edges already elapsed since the download dropped
  task automatic release_chk(input string tag, input int start, input bit exp_ok);
    int early;
    early = 0;
    for (int c = start + 1; c <= HOLD + 1; c++) begin
      @(posedge clk_sys); #1;
      if ((c <= HOLD) && (bus.core_reset !== 1'b1)) early++;
    end
    chk({"hold_reset_", tag}, early, 0);
    chk({"released_", tag}, {31'd0, bus.core_reset}, 0);
    chk({"dl_ok_", tag}, {31'd0, bus.dl_ok}, {31'd0, exp_ok});
    chk({"dl_err_", tag}, {31'd0, bus.dl_err}, {31'd0, !exp_ok});
  endtask

  initial begin
    vec_t vt[10];
    logic [24:0] last_a;
    int w0;
    int bad;

    vt[0] = '{25'h0000000, 1'b1, 3'b001, 1'b0};
    vt[1] = '{25'h0000BFF, 1'b1, 3'b001, 1'b0};
    vt[2] = '{25'h0000C00, 1'b1, 3'b010, 1'b0};
    vt[3] = '{25'h00013FF, 1'b1, 3'b010, 1'b0};
    vt[4] = '{25'h0001400, 1'b1, 3'b100, 1'b0};
    vt[5] = '{25'h00017FF, 1'b1, 3'b100, 1'b0};
    vt[6] = '{25'h0020005, 1'b0, 3'b000, 1'b1};
    vt[7] = '{25'h0001800, 1'b0, 3'b000, 1'b1};
    vt[8] = '{25'h1000000, 1'b0, 3'b000, 1'b1};
    vt[9] = '{25'h0000800, 1'b1, 3'b001, 1'b1};

    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;

    // Reset values while reset is held
    repeat (3) @(negedge clk_sys);
    chk("rst_core_reset", {31'd0, bus.core_reset}, 1);
    chk("rst_dn_wr", {31'd0, bus.dn_wr}, 0);
    chk("rst_dn_addr", {15'd0, bus.dn_addr}, 0);
    chk("rst_dn_data", {24'd0, bus.dn_data}, 0);
    chk("rst_rom_sel", {29'd0, bus.rom_sel}, 0);
    chk("rst_dl_ok", {31'd0, bus.dl_ok}, 0);
    chk("rst_dl_err", {31'd0, bus.dl_err}, 0);
    @(posedge clk_sys); #1 reset = 1'b0;

    // Strobe with no download in progress is dropped
    @(posedge clk_sys); #1 bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h10;
    @(posedge clk_sys); #1 bus.ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("idle_dn_wr", {31'd0, bus.dn_wr}, 0);
    chk("idle_core_reset", {31'd0, bus.core_reset}, 1);

    // Vector table: region decode, range gating and error flag per strobe
    start_dl();
    chk("load_core_reset", {31'd0, bus.core_reset}, 1);
    last_a = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_sys); #1;
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = vt[i].addr;
      bus.ioctl_dout = dat(vt[i].addr);
      @(posedge clk_sys); #1 bus.ioctl_wr = 1'b0;
      @(negedge clk_sys);
      chk($sformatf("vec%0d_dn_wr", i), {31'd0, bus.dn_wr}, {31'd0, vt[i].wr});
      chk($sformatf("vec%0d_dl_err", i), {31'd0, bus.dl_err}, {31'd0, vt[i].err});
      if (vt[i].wr) last_a = vt[i].addr;
      chk($sformatf("vec%0d_dn_addr", i), {15'd0, bus.dn_addr}, {15'd0, last_a[16:0]});
      chk($sformatf("vec%0d_dn_data", i), {24'd0, bus.dn_data}, {24'd0, dat(last_a)});
      if (vt[i].wr) chk($sformatf("vec%0d_rom_sel", i), {29'd0, bus.rom_sel}, {29'd0, vt[i].sel});
    end
    @(posedge clk_sys); #1 bus.ioctl_download = 1'b0;
    release_chk("vectors", 0, 1'b0);

    // Strobe while the core runs is dropped
    @(posedge clk_sys); #1 bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h20;
    @(posedge clk_sys); #1 bus.ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("run_dn_wr", {31'd0, bus.dn_wr}, 0);
    chk("run_core_reset", {31'd0, bus.core_reset}, 0);

    // Full image, final strobe on the download falling edge
    @(posedge clk_sys); #1 bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    chk("cr_before_rise", {31'd0, bus.core_reset}, 0);
    @(posedge clk_sys); #1;
    chk("cr_after_rise", {31'd0, bus.core_reset}, 1);
    chk("err_cleared", {31'd0, bus.dl_err}, 0);
    w0 = wr_seen;
    stream("full_edge", int'(S_END), 1'b1, -1);
    release_chk("full_edge", 1, 1'b1);
    chk("wr_count_full_edge", wr_seen - w0, S_END);

    // Re-download 5 cycles into the hold interval
    start_dl();
    stream("full_a", int'(S_END), 1'b0, -1);
    repeat (5) begin
      @(posedge clk_sys); #1;
    end
    chk("hold5_dl_ok", {31'd0, bus.dl_ok}, 1);
    chk("hold5_core_reset", {31'd0, bus.core_reset}, 1);
    bus.ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    chk("redl_ok_cleared", {31'd0, bus.dl_ok}, 0);
    bad = 0;
    repeat (20) begin
      @(posedge clk_sys); #1;
      if (bus.core_reset !== 1'b1) bad++;
    end
    chk("redl_core_reset", bad, 0);
    w0 = wr_seen;
    stream("full_b", int'(S_END), 1'b0, -1);
    release_chk("full_b", 0, 1'b1);
    chk("wr_count_full_b", wr_seen - w0, S_END);

    // Full image with one overrun strobe inserted
    start_dl();
    w0 = wr_seen;
    stream("overrun", int'(S_END), 1'b0, 100);
    release_chk("overrun", 0, 1'b0);
    chk("wr_count_overrun", wr_seen - w0, S_END);

    // Short image
    start_dl();
    w0 = wr_seen;
    stream("short", 'h1000, 1'b0, -1);
    release_chk("short", 0, 1'b0);
    chk("wr_count_short", wr_seen - w0, 'h1000);

    // Asynchronous reset in the middle of a load
    start_dl();
    for (int a = 0; a <= 'h1234; a++) begin
      @(posedge clk_sys); #1;
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(a);
      bus.ioctl_dout = dat(25'(a));
    end
    @(negedge clk_sys);
    chk("pre_rst_dn_wr", {31'd0, bus.dn_wr}, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_core_reset", {31'd0, bus.core_reset}, 1);
    chk("arst_dn_wr", {31'd0, bus.dn_wr}, 0);
    chk("arst_dn_addr", {15'd0, bus.dn_addr}, 0);
    chk("arst_dn_data", {24'd0, bus.dn_data}, 0);
    chk("arst_rom_sel", {29'd0, bus.rom_sel}, 0);
    chk("arst_dl_ok", {31'd0, bus.dl_ok}, 0);
    chk("arst_dl_err", {31'd0, bus.dl_err}, 0);
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    start_dl();
    w0 = wr_seen;
    stream("after_rst", int'(S_END), 1'b0, -1);
    release_chk("after_rst", 0, 1'b1);
    chk("wr_count_after_rst", wr_seen - w0, S_END);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
